sram_sp_be_model: RTL and testbench

//  Parametrised single-port synchronous SRAM model for the JPEG datapath buffers.

---
 rtl/sram_sp_be_model_pkg.sv | 22 ++
 rtl/sram_sp_be_model_if.sv | 29 ++
 rtl/sram_sp_be_model_clear_fsm.sv | 54 +++++
 rtl/sram_sp_be_model.sv | 126 ++++++++++++
 tb/tb_sram_sp_be_model.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/sram_sp_be_model_pkg.sv
// Shared types for the JPEG buffer SRAM model: clear-FSM states and access decode.
// Pure declarations, no latency and no backpressure of their own.
package jpeg_sram_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_t;

    // Encoded as {iWen, iCsn}; any cycle with iCsn high or the clear engine running is idle.
    localparam logic [1:0] ACC_WRITE = 2'b00;
    localparam logic [1:0] ACC_READ  = 2'b10;
    localparam logic [1:0] ACC_IDLE  = 2'b11;

    function automatic logic [1:0] acc_decode(input logic csn, input logic wen, input logic busy);
        if (busy || csn) begin
            return ACC_IDLE;
        end
        return {wen, 1'b0};
    endfunction

endpackage

// File: rtl/sram_sp_be_model_if.sv
// Access bus of the single-port byte-enable SRAM model.
// Single-cycle command; read data returns with a one-cycle oQValid strobe; oBusy stalls commands.
interface sram_sp_be_model_if #(
    parameter int ADDRESSSIZE = 15,
    parameter int WORDSIZE    = 80,
    parameter int BYTESIZE    = 8
);
    localparam int NBYTE = WORDSIZE / BYTESIZE;

    logic                   iCsn;
    logic                   iWen;
    logic [ADDRESSSIZE-1:0] iA;
    logic [WORDSIZE-1:0]    iD;
    logic [NBYTE-1:0]       iBe;
    logic [WORDSIZE-1:0]    oQ;
    logic                   oQValid;
    logic                   oBusy;

    modport master (
        output iCsn, iWen, iA, iD, iBe,
        input  oQ, oQValid, oBusy
    );

    modport slave (
        input  iCsn, iWen, iA, iD, iBe,
        output oQ, oQValid, oBusy
    );

endinterface

// File: rtl/sram_sp_be_model_clear_fsm.sv
// Post-reset clear engine: walks every word address once, one word per cycle.
// Takes 2**ADDRESSSIZE cycles; oBusy holds off all array accesses until the last word is written.
module sram_clear_fsm
    import jpeg_sram_pkg::*;
#(
    parameter int ADDRESSSIZE    = 15,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                   iClk,
    input  logic                   iReset,
    output logic                   oBusy,
    output logic                   oClrVld,
    output logic [ADDRESSSIZE-1:0] oClrAddr
);

    localparam clr_state_t ST_AFTER_RESET = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;

    clr_state_t             r_state;
    clr_state_t             w_state_nxt;
    logic [ADDRESSSIZE-1:0] r_cnt;
    logic [ADDRESSSIZE-1:0] w_cnt_nxt;

    always_ff @(posedge iClk or negedge iReset) begin
        if (!iReset) begin
            r_state <= ST_AFTER_RESET;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        oBusy       = 1'b0;
        oClrVld     = 1'b0;
        case (r_state)
            ST_CLEAR: begin
                oBusy     = 1'b1;
                oClrVld   = 1'b1;
                w_cnt_nxt = r_cnt + 1'b1;
                if (r_cnt == {ADDRESSSIZE{1'b1}}) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
            end
        endcase
    end

    assign oClrAddr = r_cnt;

endmodule

// File: rtl/sram_sp_be_model.sv
// Single-port synchronous SRAM model with byte-lane writes and an optional post-reset clear.
// Read data after READLATENCY (1 or 2) cycles with oQValid; accesses are dropped while oBusy is high.
module sram_sp_be_model
    import jpeg_sram_pkg::*;
#(
    parameter int ADDRESSSIZE    = 15,
    parameter int WORDSIZE       = 80,
    parameter int BYTESIZE       = 8,
    parameter int READLATENCY    = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              iClk,
    input  logic              iReset,
    sram_sp_be_model_if.slave bus
);

    localparam int NBYTE = WORDSIZE / BYTESIZE;
    localparam int DEPTH = 2 ** ADDRESSSIZE;

    generate
        if ((WORDSIZE % BYTESIZE) != 0) begin : g_bad_width
            $error("WORDSIZE must be a multiple of BYTESIZE");
        end
        if ((READLATENCY != 1) && (READLATENCY != 2)) begin : g_bad_latency
            $error("READLATENCY must be 1 or 2");
        end
    endgenerate

    logic [WORDSIZE-1:0]    r_mem [0:DEPTH-1];
    logic                   w_busy;
    logic                   w_clr_vld;
    logic [ADDRESSSIZE-1:0] w_clr_addr;
    logic [1:0]             w_acc;
    logic [WORDSIZE-1:0]    w_rd_cur;
    logic                   w_rd_vld;
    logic                   w_mem_we;
    logic [ADDRESSSIZE-1:0] w_mem_addr;
    logic [WORDSIZE-1:0]    w_mem_dat;
    logic                   w_out_vld;
    logic [WORDSIZE-1:0]    w_out_dat;
    logic [WORDSIZE-1:0]    r_q;
    logic                   r_q_vld;

    sram_clear_fsm #(
        .ADDRESSSIZE    (ADDRESSSIZE),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_clear_fsm (
        .iClk     (iClk),
        .iReset   (iReset),
        .oBusy    (w_busy),
        .oClrVld  (w_clr_vld),
        .oClrAddr (w_clr_addr)
    );

    assign w_acc    = acc_decode(bus.iCsn, bus.iWen, w_busy);
    assign w_rd_cur = r_mem[bus.iA];
    assign w_rd_vld = (w_acc == ACC_READ);

    // Partial writes merge the new lanes into the current word so the array sees one full-word write.
    always_comb begin
        w_mem_we   = 1'b0;
        w_mem_addr = bus.iA;
        w_mem_dat  = w_rd_cur;
        if (w_clr_vld) begin
            w_mem_we   = 1'b1;
            w_mem_addr = w_clr_addr;
            w_mem_dat  = '0;
        end else if ((w_acc == ACC_WRITE) && (|bus.iBe)) begin
            w_mem_we = 1'b1;
            for (int k = 0; k < NBYTE; k++) begin
                if (bus.iBe[k]) begin
                    w_mem_dat[k*BYTESIZE +: BYTESIZE] = bus.iD[k*BYTESIZE +: BYTESIZE];
                end
            end
        end
    end

    always_ff @(posedge iClk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_dat;
        end
    end

    generate
        if (READLATENCY == 2) begin : g_rl2
            logic                r_s1_vld;
            logic [WORDSIZE-1:0] r_s1_dat;

            always_ff @(posedge iClk or negedge iReset) begin
                if (!iReset) begin
                    r_s1_vld <= 1'b0;
                    r_s1_dat <= '0;
                end else begin
                    r_s1_vld <= w_rd_vld;
                    if (w_rd_vld) begin
                        r_s1_dat <= w_rd_cur;
                    end
                end
            end

            assign w_out_vld = r_s1_vld;
            assign w_out_dat = r_s1_dat;
        end else begin : g_rl1
            assign w_out_vld = w_rd_vld;
            assign w_out_dat = w_rd_cur;
        end
    endgenerate

    // oQ only moves when a read completes, so consumers may sample it any time after the strobe.
    always_ff @(posedge iClk or negedge iReset) begin
        if (!iReset) begin
            r_q     <= '0;
            r_q_vld <= 1'b0;
        end else begin
            r_q_vld <= w_out_vld;
            if (w_out_vld) begin
                r_q <= w_out_dat;
            end
        end
    end

    assign bus.oQ      = r_q;
    assign bus.oQValid = r_q_vld;
    assign bus.oBusy   = w_busy;

endmodule

// File: tb/tb_sram_sp_be_model.sv
// Three model instances (latency 1 / latency 2 / no clear) driven by one shared random+directed stream.
// A word-level reference array per instance feeds a scoreboard; a negedge monitor checks every cycle.
module tb_sram_sp_be_model;

    localparam int N  = 3;
    localparam int AW = 4;
    localparam int DW = 32;

    typedef struct packed {
        logic [31:0] dat;
        logic [31:0] msk;
        int          due;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        s_csn;
    logic        s_wen;
    logic [3:0]  s_a;
    logic [31:0] s_d;
    logic [3:0]  s_be;

    exp_t        sbq     [N][$];
    logic [31:0] mem_m   [N][16];
    logic [31:0] known_m [N][16];
    logic [31:0] last_q  [N];
    logic [31:0] last_m  [N];
    int          edges;
    int          cyc;
    int          checks;
    int          failures;

    logic [31:0] dq    [N];
    logic        dqv   [N];
    logic        dbusy [N];

    sram_sp_be_model_if #(.ADDRESSSIZE(AW), .WORDSIZE(DW), .BYTESIZE(8)) if_a ();
    sram_sp_be_model_if #(.ADDRESSSIZE(AW), .WORDSIZE(DW), .BYTESIZE(8)) if_b ();
    sram_sp_be_model_if #(.ADDRESSSIZE(AW), .WORDSIZE(DW), .BYTESIZE(8)) if_c ();

    sram_sp_be_model #(.ADDRESSSIZE(AW), .WORDSIZE(DW), .BYTESIZE(8), .READLATENCY(1), .CLEAR_ON_RESET(1))
        dut_a (.iClk(clk), .iReset(rst_n), .bus(if_a));
    sram_sp_be_model #(.ADDRESSSIZE(AW), .WORDSIZE(DW), .BYTESIZE(8), .READLATENCY(2), .CLEAR_ON_RESET(1))
        dut_b (.iClk(clk), .iReset(rst_n), .bus(if_b));
    sram_sp_be_model #(.ADDRESSSIZE(AW), .WORDSIZE(DW), .BYTESIZE(8), .READLATENCY(1), .CLEAR_ON_RESET(0))
        dut_c (.iClk(clk), .iReset(rst_n), .bus(if_c));

    assign if_a.iCsn = s_csn; assign if_a.iWen = s_wen; assign if_a.iA = s_a; assign if_a.iD = s_d; assign if_a.iBe = s_be;
    assign if_b.iCsn = s_csn; assign if_b.iWen = s_wen; assign if_b.iA = s_a; assign if_b.iD = s_d; assign if_b.iBe = s_be;
    assign if_c.iCsn = s_csn; assign if_c.iWen = s_wen; assign if_c.iA = s_a; assign if_c.iD = s_d; assign if_c.iBe = s_be;

    assign dq[0] = if_a.oQ; assign dqv[0] = if_a.oQValid; assign dbusy[0] = if_a.oBusy;
    assign dq[1] = if_b.oQ; assign dqv[1] = if_b.oQValid; assign dbusy[1] = if_b.oBusy;
    assign dq[2] = if_c.oQ; assign dqv[2] = if_c.oQValid; assign dbusy[2] = if_c.oBusy;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int rl_of(input int d);
        return (d == 1) ? 2 : 1;
    endfunction

    function automatic bit cor_of(input int d);
        return (d != 2);
    endfunction

    task automatic chk(input string nm, input int d, input logic [31:0] act,
                       input logic [31:0] exp, input logic [31:0] msk);
        checks++;
        if (((act ^ exp) & msk) !== 32'h0) begin
            failures++;
            $display("FAIL %s dut%0d cyc=%0d actual=%h required=%h mask=%h", nm, d, cyc, act, exp, msk);
        end
    endtask

    // Reference: accesses are blocked for the first 16 edges after release on clearing instances.
    always @(posedge clk) begin
        if (rst_n) begin
            bit blk;
            blk = (edges < 16);
            cyc++;
            for (int d = 0; d < N; d++) begin
                if (!s_csn && !(cor_of(d) && blk)) begin
                    if (s_wen) begin
                        sbq[d].push_back('{mem_m[d][s_a], known_m[d][s_a], cyc + rl_of(d) - 1});
                    end else begin
                        for (int k = 0; k < 4; k++) begin
                            if (s_be[k]) begin
                                mem_m[d][s_a][k*8 +: 8]   = s_d[k*8 +: 8];
                                known_m[d][s_a][k*8 +: 8] = 8'hFF;
                            end
                        end
                    end
                end
            end
            if (edges < 16) edges++;
        end
    end

    always @(negedge clk) begin
        for (int d = 0; d < N; d++) begin
            exp_t e;
            bit   ev;
            while (sbq[d].size() > 0 && sbq[d][0].due < cyc) begin
                checks++;
                failures++;
                $display("FAIL late_read dut%0d cyc=%0d actual=none required=%h", d, cyc, sbq[d][0].dat);
                void'(sbq[d].pop_front());
            end
            ev = (sbq[d].size() > 0) && (sbq[d][0].due == cyc);
            chk("busy", d, {31'b0, dbusy[d]}, {31'b0, (cor_of(d) && edges < 16)}, 32'h1);
            chk("qvalid", d, {31'b0, dqv[d]}, {31'b0, ev}, 32'h1);
            if (ev) begin
                e = sbq[d].pop_front();
                last_q[d] = e.dat;
                last_m[d] = e.msk;
                chk("read_data", d, dq[d], e.dat, e.msk);
            end else begin
                chk("q_hold", d, dq[d], last_q[d], last_m[d]);
            end
        end
    end

    task automatic do_reset(input int hold);
        rst_n = 1'b0;
        edges = 0;
        for (int d = 0; d < N; d++) begin
            sbq[d].delete();
            last_q[d] = 32'h0;
            last_m[d] = 32'hFFFF_FFFF;
            if (cor_of(d)) begin
                for (int a = 0; a < 16; a++) begin
                    mem_m[d][a]   = 32'h0;
                    known_m[d][a] = 32'hFFFF_FFFF;
                end
            end
        end
        repeat (hold) begin @(posedge clk); #2; end
        rst_n = 1'b1;
    endtask

    task automatic op(input bit wen, input int a, input logic [31:0] d, input logic [3:0] be);
        s_csn = 1'b0; s_wen = wen; s_a = 4'(a); s_d = d; s_be = be;
        @(posedge clk); #2;
    endtask

    task automatic idle(input int n);
        s_csn = 1'b1; s_wen = 1'b1; s_be = 4'h0;
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic rand_ops(input int n);
        repeat (n) begin
            if ($urandom_range(3, 0) == 0) begin
                idle(1);
            end else begin
                op(1'($urandom_range(1, 0)), int'($urandom_range(15, 0)), $urandom, 4'($urandom_range(15, 0)));
            end
        end
    endtask

    initial begin
        checks = 0; failures = 0; cyc = 0; edges = 0;
        s_csn = 1'b1; s_wen = 1'b1; s_a = 4'h0; s_d = 32'h0; s_be = 4'h0;
        for (int a = 0; a < 16; a++) known_m[2][a] = 32'h0;
        do_reset(3);

        // Accesses during clear: ignored by clearing instances, accepted by the non-clearing one.
        idle(2);
        op(1'b0, 2, 32'hFFFF_FFFF, 4'hF);
        op(1'b1, 2, 32'h0, 4'h0);
        idle(16);

        for (int a = 0; a < 16; a++) op(1'b1, a, 32'h0, 4'h0);
        idle(3);

        op(1'b0, 3, 32'hDEAD_BEEF, 4'hF);
        op(1'b0, 3, 32'h1122_3344, 4'b0101);
        op(1'b1, 3, 32'h0, 4'h0);
        idle(3);
        for (int d = 0; d < N; d++) chk("be_merge", d, dq[d], 32'hDE22_BE44, 32'hFFFF_FFFF);

        op(1'b0, 0, 32'd5, 4'hF);
        op(1'b0, 1, 32'd6, 4'hF);
        op(1'b0, 2, 32'd7, 4'hF);
        op(1'b1, 0, 32'h0, 4'h0);
        op(1'b1, 1, 32'h0, 4'h0);
        op(1'b1, 2, 32'h0, 4'h0);
        idle(4);
        for (int d = 0; d < N; d++) chk("burst_last", d, dq[d], 32'd7, 32'hFFFF_FFFF);

        op(1'b0, 5, 32'd9, 4'hF);
        op(1'b1, 5, 32'h0, 4'h0);
        idle(4);
        for (int d = 0; d < N; d++) chk("idle_hold", d, dq[d], 32'd9, 32'hFFFF_FFFF);

        rand_ops(400);
        idle(3);

        // Reset again, then interrupt the clear half way through.
        do_reset(2);
        idle(8);
        do_reset(2);
        rand_ops(150);
        idle(3);
        for (int a = 0; a < 16; a++) op(1'b1, a, 32'h0, 4'h0);
        idle(4);

        for (int d = 0; d < N; d++) chk("sb_drained", d, 32'(sbq[d].size()), 32'h0, 32'hFFFF_FFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
